qkv_projection_sequencer: RTL and testbench
===========================================

Name: qkv_projection_sequencer

Overview:
Controller that computes the Q, K and V projections of one attention head. It does this by running a single shared matrix_multiply engine three times in sequence: Q = X*Wq, K = X*Wk, V = X*Wv. Operands are latched on START and muxed onto the engine port. Each engine result is captured into its own output bank, and DONE is raised once all three are valid. The block sits between the attention top-level control and the one matrix_multiply instance, which lives outside this block.

Parameters:
N, 3, rows of X (sequence length)
Din, 3, inner dimension (columns of X, rows of W*)
Dout, 3, columns of W* and of Q/K/V
WIDTHA, 8, signed element width of X
WIDTHB, 8, signed element width of Wq/Wk/Wv
TIMEOUT, 1024, maximum cycles allowed in any engine wait state before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
START  in  1  level request; accepted in IDLE
x  in  signed [WIDTHA-1:0] [N][Din]  input activations
wq, wk, wv  in  signed [WIDTHB-1:0] [Din][Dout]  projection weights
mm_start  out  1  START of shared matrix_multiply
mm_a  out  signed [WIDTHA-1:0] [N][Din]  engine operand a (latched x)
mm_b  out  signed [WIDTHB-1:0] [Din][Dout]  engine operand b (weight selected by phase)
mm_c  in  signed [WIDTHA+WIDTHB-1:0] [N][Dout]  engine result
mm_done  in  1  DONE of engine
q, k, v  out  signed [WIDTHA+WIDTHB-1:0] [N][Dout]  captured projections
phase  out  2  0=Q, 1=K, 2=V, 3=idle/finished
DONE  out  1  all three projections valid
err  out  1  engine timeout occurred

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; mm_start=0, DONE=0, err=0, phase=3, timeout counter=0; q/k/v and latched operands all 0.
- All outputs are registered. mm_a/mm_b are driven from the internal operand registers only, never directly from the inputs.

State machine:
- IDLE: when START=1, latch x, wq, wk, wv; set phase=0 and mm_start=1; go to ISSUE.
- ISSUE:
  - mm_start held at 1; counter increments each cycle.
  - If mm_done=1: capture mm_c into the bank selected by phase (0->q, 1->k, 2->v), set mm_start=0, clear counter, go to DRAIN.
  - If counter reaches TIMEOUT: go to ERR.
- DRAIN:
  - mm_start=0; wait for mm_done=0, which is the engine's return-to-idle.
  - When mm_done=0: if phase<2, set phase+1, mm_start=1, clear counter, go to ISSUE. If phase=2, set phase=3, go to FINISH.
  - If counter reaches TIMEOUT: go to ERR.
- FINISH: DONE=1, held while START=1. When START=0, clear DONE and go to IDLE. A new run therefore needs START to go low and then high again.
- ERR: err=1, DONE=1, mm_start=0, phase=3. Hold until START=0, then clear err and DONE and go to IDLE. q/k/v keep whatever was captured before the error.

Data and timing rules:
- mm_start rises exactly 1 cycle after acceptance, and 1 cycle after the DRAIN exit of the previous phase.
- Capture happens on the same edge on which mm_done is first seen high in ISSUE.
- q/k/v banks of earlier phases stay stable while later phases run. No bank is cleared at the start of a new run.
- Operand changes on x/w* after acceptance have no effect until the next run.
- Results are copied bit-exact from mm_c; no truncation or rounding.

Boundary conditions:
- reset asserted in any state overrides everything on that edge: IDLE, mm_start=0 and all outputs at reset values.
- START dropped mid-run (ISSUE/DRAIN) is ignored; the sequence completes.
- mm_done high in IDLE or FINISH is ignored.
- mm_done already high on ISSUE entry is treated as completion.
- The counter saturates; there is no wrap-around.

Decomposition:
- Shared attn_pkg holds:
  - enum seq_state_t {IDLE, ISSUE, DRAIN, FINISH, ERR}
  - enum phase_t {PH_Q=0, PH_K=1, PH_V=2, PH_NONE=3}
  - localparam for timeout counter width, $clog2(TIMEOUT+1)
- No sub-module. The weight-select mux and bank write-enable decode stay inline. The engine is instantiated by the parent.

Test Plan:
1. Nominal run, engine model with 4-cycle latency:
   - Stimulus: x = [[-1,2,-3],[4,-5,6],[-7,8,-9]]; wq = identity; wk = x; wv = -identity.
   - Required: q = x; k = [[30,-36,42],[-66,81,-96],[102,-126,150]]; v = -x.
   - Required: DONE rises after exactly three mm_start pulses, with phase sequence 0,1,2,3.
2. DONE handshake: hold START high for 10 cycles after DONE -> DONE stays 1. Drop START -> DONE=0 and IDLE next edge. Reassert START -> new run with fresh operands.
3. Timeout: set TIMEOUT=16 and an engine that never asserts mm_done -> err=1 and DONE=1 at cycle 17 after mm_start rose; mm_start=0; q/k/v still 0.
4. Reset mid-run: assert reset during phase 1 (ISSUE) -> next edge mm_start=0, phase=3, q/k/v=0. A subsequent START completes the correct results.
5. Sticky engine DONE: the model holds mm_done high for 3 cycles after mm_start falls -> the sequencer stays in DRAIN and the next mm_start rises only after mm_done=0. Each bank is captured exactly once (check with a capture counter).
6. Operand isolation: change x and wk on the cycle after acceptance -> results match the originally latched values.

Source files
------------

// File: rtl/attn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : attn_pkg
// Description : Shared types and constants for the attention-head control
//               blocks (sequencer states, projection phases, timeout sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package attn_pkg;

    // Default engine wait budget in cycles and the matching counter width
    localparam int C_TIMEOUT_DEFAULT = 1024;
    localparam int C_CNT_W_DEFAULT   = $clog2(C_TIMEOUT_DEFAULT + 1);

    // Counter width able to hold the value TIMEOUT itself
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        FINISH = 3'd3,
        ERR    = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_Q    = 2'd0,
        PH_K    = 2'd1,
        PH_V    = 2'd2,
        PH_NONE = 2'd3
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/qkv_projection_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qkv_projection_sequencer
// Description : Runs one shared matrix_multiply engine three times to form
//               Q = X*Wq, K = X*Wk, V = X*Wv, capturing each result into its
//               own bank and raising DONE when all three are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module qkv_projection_sequencer
    import attn_pkg::*;
#(
    parameter int N       = 3,
    parameter int DIN     = 3,
    parameter int DOUT    = 3,
    parameter int WIDTHA  = 8,
    parameter int WIDTHB  = 8,
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            START,
    input  logic signed [WIDTHA-1:0]        x  [N][DIN],
    input  logic signed [WIDTHB-1:0]        wq [DIN][DOUT],
    input  logic signed [WIDTHB-1:0]        wk [DIN][DOUT],
    input  logic signed [WIDTHB-1:0]        wv [DIN][DOUT],
    output logic                            mm_start,
    output logic signed [WIDTHA-1:0]        mm_a [N][DIN],
    output logic signed [WIDTHB-1:0]        mm_b [DIN][DOUT],
    input  logic signed [WIDTHA+WIDTHB-1:0] mm_c [N][DOUT],
    input  logic                            mm_done,
    output logic signed [WIDTHA+WIDTHB-1:0] q  [N][DOUT],
    output logic signed [WIDTHA+WIDTHB-1:0] k  [N][DOUT],
    output logic signed [WIDTHA+WIDTHB-1:0] v  [N][DOUT],
    output logic [1:0]                      phase,
    output logic                            DONE,
    output logic                            err
);

    localparam int                 C_CNT_W   = cnt_width(TIMEOUT);
    localparam int                 C_WC      = WIDTHA + WIDTHB;
    localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT);

    seq_state_t         r_state, w_state_nxt;
    phase_t             r_phase, w_phase_nxt;
    logic               r_mm_start, w_mm_start_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic               w_latch, w_capture;

    logic signed [WIDTHA-1:0] r_x  [N][DIN];
    logic signed [WIDTHB-1:0] r_wq [DIN][DOUT];
    logic signed [WIDTHB-1:0] r_wk [DIN][DOUT];
    logic signed [WIDTHB-1:0] r_wv [DIN][DOUT];
    logic signed [C_WC-1:0]   r_q  [N][DOUT];
    logic signed [C_WC-1:0]   r_k  [N][DOUT];
    logic signed [C_WC-1:0]   r_v  [N][DOUT];

    // Wait counter saturates at TIMEOUT instead of wrapping
    assign w_cnt_inc = (r_cnt >= C_TIMEOUT) ? r_cnt : r_cnt + 1'b1;

    // Control registers; every control output comes straight from a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_phase    <= PH_NONE;
            r_mm_start <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_mm_start <= w_mm_start_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Next-state and next-output decode for the three-phase sequence
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_mm_start_nxt = r_mm_start;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_cnt_nxt      = r_cnt;
        w_latch        = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_latch        = 1'b1;
                    w_phase_nxt    = PH_Q;
                    w_mm_start_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                // A done already high on entry counts as completion
                if (mm_done) begin
                    w_capture      = 1'b1;
                    w_mm_start_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = DRAIN;
                end else if (r_cnt >= C_TIMEOUT) begin
                    w_err_nxt      = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_mm_start_nxt = 1'b0;
                    w_phase_nxt    = PH_NONE;
                    w_state_nxt    = ERR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            DRAIN: begin
                // Engine must return to idle before it may be restarted
                if (!mm_done) begin
                    if (r_phase == PH_V) begin
                        w_phase_nxt = PH_NONE;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = FINISH;
                    end else begin
                        w_phase_nxt    = phase_t'(r_phase + 2'd1);
                        w_mm_start_nxt = 1'b1;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = ISSUE;
                    end
                end else if (r_cnt >= C_TIMEOUT) begin
                    w_err_nxt      = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_mm_start_nxt = 1'b0;
                    w_phase_nxt    = PH_NONE;
                    w_state_nxt    = ERR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            FINISH: begin
                if (!START) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            ERR: begin
                if (!START) begin
                    w_err_nxt   = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_phase_nxt    = PH_NONE;
                w_mm_start_nxt = 1'b0;
                w_done_nxt     = 1'b0;
                w_err_nxt      = 1'b0;
                w_cnt_nxt      = '0;
            end
        endcase
    end

    // Operand latches and result banks; only the bank of the current phase is written
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x  <= '{default: '0};
            r_wq <= '{default: '0};
            r_wk <= '{default: '0};
            r_wv <= '{default: '0};
            r_q  <= '{default: '0};
            r_k  <= '{default: '0};
            r_v  <= '{default: '0};
        end else begin
            if (w_latch) begin
                r_x  <= x;
                r_wq <= wq;
                r_wk <= wk;
                r_wv <= wv;
            end
            if (w_capture) begin
                case (r_phase)
                    PH_Q:    r_q <= mm_c;
                    PH_K:    r_k <= mm_c;
                    PH_V:    r_v <= mm_c;
                    default: ;
                endcase
            end
        end
    end

    // Weight operand follows the phase; X is shared by all three passes
    always_comb begin
        case (r_phase)
            PH_K:    mm_b = r_wk;
            PH_V:    mm_b = r_wv;
            default: mm_b = r_wq;
        endcase
    end

    assign mm_a     = r_x;
    assign mm_start = r_mm_start;
    assign q        = r_q;
    assign k        = r_k;
    assign v        = r_v;
    assign phase    = r_phase;
    assign DONE     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qkv_projection_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qkv_projection_sequencer
// Description : Self-checking bench with a behavioural matrix engine and a
//               plain-arithmetic reference for the Q/K/V projections.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qkv_projection_sequencer;

    localparam int N  = 3;
    localparam int D  = 3;
    localparam int WC = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset, START, mm_start, mm_done, DONE, err;
    logic [1:0] phase;
    logic signed [7:0]    x  [N][D];
    logic signed [7:0]    wq [D][D];
    logic signed [7:0]    wk [D][D];
    logic signed [7:0]    wv [D][D];
    logic signed [7:0]    mm_a [N][D];
    logic signed [7:0]    mm_b [D][D];
    logic signed [WC-1:0] mm_c [N][D];
    logic signed [WC-1:0] q [N][D];
    logic signed [WC-1:0] k [N][D];
    logic signed [WC-1:0] v [N][D];

    // Reference copies of the operands applied at acceptance and expected banks
    logic signed [7:0]    sx  [N][D];
    logic signed [7:0]    swq [D][D];
    logic signed [7:0]    swk [D][D];
    logic signed [7:0]    swv [D][D];
    logic signed [WC-1:0] eq [N][D];
    logic signed [WC-1:0] ek [N][D];
    logic signed [WC-1:0] ev [N][D];

    int n_chk = 0;
    int n_err = 0;

    qkv_projection_sequencer #(
        .N(N), .DIN(D), .DOUT(D), .WIDTHA(8), .WIDTHB(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .START(START),
        .x(x), .wq(wq), .wk(wk), .wv(wv),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_done(mm_done),
        .q(q), .k(k), .v(v), .phase(phase), .DONE(DONE), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural engine: fixed latency, optional sticky done, optional hang
    int  eng_lat = 4;
    int  eng_sticky = 0;
    bit  eng_hang = 1'b0;
    int  e_st, e_cnt, e_stk;

    function automatic logic signed [WC-1:0] dotp(input int i, input int j);
        int s = 0;
        for (int d = 0; d < D; d++) s += int'(mm_a[i][d]) * int'(mm_b[d][j]);
        return WC'(s);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            e_st <= 0; e_cnt <= 0; e_stk <= 0; mm_done <= 1'b0;
        end else begin
            case (e_st)
                0: if (mm_start && !eng_hang) begin e_cnt <= eng_lat; e_st <= 1; end
                1: if (e_cnt <= 1) begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < D; j++) mm_c[i][j] <= dotp(i, j);
                        mm_done <= 1'b1; e_st <= 2; e_stk <= eng_sticky;
                    end else e_cnt <= e_cnt - 1;
                default: if (!mm_start) begin
                        if (e_stk > 0) e_stk <= e_stk - 1;
                        else begin mm_done <= 1'b0; e_st <= 0; end
                    end
            endcase
        end
    end

    // Port-level monitor: start pulses, captures, restarts into a busy engine, phase trace
    int n_rise = 0, n_cap = 0, n_bad = 0;
    logic prev_start;
    logic [1:0] prev_phase;
    logic [1:0] ph_log [$];
    always @(negedge clk) begin
        if (!reset) begin
            if (mm_start && !prev_start) begin
                n_rise <= n_rise + 1;
                if (mm_done) n_bad <= n_bad + 1;
            end
            if (mm_start && mm_done) n_cap <= n_cap + 1;
            if (phase !== prev_phase) ph_log.push_back(phase);
        end
        prev_start <= mm_start;
        prev_phase <= phase;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void matmul(input logic signed [7:0] a [N][D],
                                   input logic signed [7:0] b [D][D],
                                   output logic signed [WC-1:0] r [N][D]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < D; j++) begin
                int s = 0;
                for (int d = 0; d < D; d++) s += int'(a[i][d]) * int'(b[d][j]);
                r[i][j] = WC'(s);
            end
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < D; j++) begin
                x[i][j]  = 8'($urandom); wq[i][j] = 8'($urandom);
                wk[i][j] = 8'($urandom); wv[i][j] = 8'($urandom);
            end
    endtask

    // Freeze the operands about to be accepted and derive the expected banks
    task automatic snapshot();
        sx = x; swq = wq; swk = wk; swv = wv;
        matmul(sx, swq, eq);
        matmul(sx, swk, ek);
        matmul(sx, swv, ev);
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!DONE && c < 3000) begin @(negedge clk); c++; end
        check_val({tag, "_done"}, 32'(DONE), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_banks(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < D; j++) begin
                check_val($sformatf("%s_q%0d%0d", tag, i, j), 32'(q[i][j]), 32'(eq[i][j]));
                check_val($sformatf("%s_k%0d%0d", tag, i, j), 32'(k[i][j]), 32'(ek[i][j]));
                check_val($sformatf("%s_v%0d%0d", tag, i, j), 32'(v[i][j]), 32'(ev[i][j]));
            end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < D; j++) begin
                check_val($sformatf("%s_q%0d%0d", tag, i, j), 32'(q[i][j]), 32'd0);
                check_val($sformatf("%s_k%0d%0d", tag, i, j), 32'(k[i][j]), 32'd0);
                check_val($sformatf("%s_v%0d%0d", tag, i, j), 32'(v[i][j]), 32'd0);
            end
    endtask

    task automatic full_run(input string tag);
        int r0, c0;
        r0 = n_rise; c0 = n_cap;
        snapshot();
        START = 1'b1;
        wait_done(tag);
        check_banks(tag);
        check_val({tag, "_rises"}, 32'(n_rise - r0), 32'd3);
        check_val({tag, "_caps"},  32'(n_cap - c0),  32'd3);
        START = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c, r0, c0, b0, p0;
        logic [1:0] ph_exp [4];
        START = 1'b0; reset = 1'b1;
        x = '{default: '0}; wq = '{default: '0}; wk = '{default: '0}; wv = '{default: '0};
        repeat (3) @(negedge clk);
        check_val("rst_mm_start", 32'(mm_start), 32'd0);
        check_val("rst_phase",    32'(phase),    32'd3);
        check_val("rst_done",     32'(DONE),     32'd0);
        check_val("rst_err",      32'(err),      32'd0);
        check_zero("rst");
        reset = 1'b0;
        @(negedge clk);

        // Nominal run with fixed operands
        x = '{'{-8'sd1, 8'sd2, -8'sd3}, '{8'sd4, -8'sd5, 8'sd6}, '{-8'sd7, 8'sd8, -8'sd9}};
        wq = '{'{8'sd1, 8'sd0, 8'sd0}, '{8'sd0, 8'sd1, 8'sd0}, '{8'sd0, 8'sd0, 8'sd1}};
        wk = x;
        wv = '{'{-8'sd1, 8'sd0, 8'sd0}, '{8'sd0, -8'sd1, 8'sd0}, '{8'sd0, 8'sd0, -8'sd1}};
        r0 = n_rise; c0 = n_cap; p0 = ph_log.size();
        snapshot();
        check_val("t1_k00_ref", 32'(ek[0][0]), 32'd30);
        START = 1'b1;
        wait_done("t1");
        check_banks("t1");
        check_val("t1_rises", 32'(n_rise - r0), 32'd3);
        check_val("t1_caps",  32'(n_cap - c0),  32'd3);
        check_val("t1_phlen", 32'(ph_log.size() - p0), 32'd4);
        ph_exp = '{2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 4; i++)
            if (p0 + i < ph_log.size())
                check_val($sformatf("t1_ph%0d", i), 32'(ph_log[p0 + i]), 32'(ph_exp[i]));

        // DONE held while START stays high, released one edge after START drops
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("t2_hold", 32'(DONE), 32'd1);
        end
        START = 1'b0;
        @(negedge clk);
        check_val("t2_drop_done", 32'(DONE), 32'd0);
        rand_ops();
        full_run("t2");

        // Timeout with an engine that never finishes
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        eng_hang = 1'b1;
        rand_ops(); snapshot();
        START = 1'b1;
        c = 0;
        while (!mm_start && c < 10) begin @(negedge clk); c++; end
        c = 0;
        while (!err && c < 100) begin @(negedge clk); c++; end
        check_val("t3_cycles",   32'(c),        32'd17);
        check_val("t3_err",      32'(err),      32'd1);
        check_val("t3_done",     32'(DONE),     32'd1);
        check_val("t3_mm_start", 32'(mm_start), 32'd0);
        check_val("t3_phase",    32'(phase),    32'd3);
        check_zero("t3");
        START = 1'b0;
        @(negedge clk);
        check_val("t3_err_clr",  32'(err),  32'd0);
        check_val("t3_done_clr", 32'(DONE), 32'd0);
        eng_hang = 1'b0;

        // Reset in the middle of the K phase
        rand_ops(); snapshot();
        START = 1'b1;
        c = 0;
        while (!(phase == 2'd1 && mm_start) && c < 200) begin @(negedge clk); c++; end
        check_val("t4_reach_k", 32'(phase), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("t4_mm_start", 32'(mm_start), 32'd0);
        check_val("t4_phase",    32'(phase),    32'd3);
        check_val("t4_done",     32'(DONE),     32'd0);
        check_zero("t4");
        reset = 1'b0; START = 1'b0;
        @(negedge clk);
        rand_ops();
        full_run("t4");

        // Engine keeps done high after start falls
        eng_sticky = 3;
        b0 = n_bad;
        rand_ops();
        full_run("t5");
        check_val("t5_bad_restart", 32'(n_bad - b0), 32'd0);
        eng_sticky = 0;

        // Inputs changed right after acceptance must not leak into results
        rand_ops(); snapshot();
        START = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < D; j++) begin
                x[i][j] = 8'($urandom); wk[i][j] = 8'($urandom);
            end
        wait_done("t6");
        check_banks("t6");
        START = 1'b0;
        @(negedge clk);

        // Randomized runs over engine latency and sticky done
        for (int r = 0; r < 8; r++) begin
            eng_lat = int'($urandom_range(1, 8));
            eng_sticky = int'($urandom_range(0, 3));
            b0 = n_bad;
            rand_ops();
            full_run($sformatf("rnd%0d", r));
            check_val($sformatf("rnd%0d_bad", r), 32'(n_bad - b0), 32'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
